// File: rtl/qsfp_seq_pkg.sv
// Shared types for the QSFP reset sequencer: FSM state encoding and status widths.
package qsfp_seq_pkg;

    typedef enum logic [2:0] {
        LEAD      = 3'd0,
        PMA       = 3'd1,
        TAIL      = 3'd2,
        WAIT_LINK = 3'd3,
        UP        = 3'd4
    } seq_state_t;

    localparam int RETRY_W = 8;

endpackage

// File: rtl/bit_sync_2ff.sv
// Single-bit two-flop synchronizer for quasi-static level signals crossing into clock.
module bit_sync_2ff (
    input  logic clock,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/qsfp_reset_sequencer.sv
// Aurora reset_pb / pma_init power-up sequencer for one QSFP channel, with
// channel_up supervision, automatic re-sequencing and a saturating retry count.
module qsfp_reset_sequencer
    import qsfp_seq_pkg::*;
#(
    parameter int LEAD_CYCLES     = 128,
    parameter int PMA_HOLD_CYCLES = 125_000_000,
    parameter int TAIL_CYCLES     = 128,
    parameter int LINK_TIMEOUT    = 250_000_000,
    parameter int LOSS_FILTER     = 16
) (
    input  logic               clock,
    input  logic               reset_in,
    input  logic               restart,
    input  logic               channel_up,
    output logic               reset_pb,
    output logic               pma_init,
    output logic               link_up,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int MAX_AB     = (LEAD_CYCLES > PMA_HOLD_CYCLES) ? LEAD_CYCLES : PMA_HOLD_CYCLES;
    localparam int MAX_CD     = (TAIL_CYCLES > LINK_TIMEOUT) ? TAIL_CYCLES : LINK_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam int LOSS_W     = $clog2(LOSS_FILTER) + 1;

    localparam logic [CNT_W-1:0]  LEAD_LOAD = CNT_W'(LEAD_CYCLES);
    localparam logic [CNT_W-1:0]  PMA_LOAD  = CNT_W'(PMA_HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  TAIL_LOAD = CNT_W'(TAIL_CYCLES);
    localparam logic [CNT_W-1:0]  LINK_LOAD = CNT_W'(LINK_TIMEOUT);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);

    logic              cu_s;
    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [LOSS_W-1:0] loss_cnt, loss_nxt;
    logic              retry_inc;

    bit_sync_2ff u_cu_sync (
        .clock (clock),
        .d     (channel_up),
        .q     (cu_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CNT_W'(1);
        loss_nxt  = loss_cnt;
        retry_inc = 1'b0;
        case (state)
            LEAD: begin
                if (cnt == '0) begin
                    state_nxt = PMA;
                    cnt_nxt   = PMA_LOAD;
                end
            end
            PMA: begin
                if (cnt == '0) begin
                    state_nxt = TAIL;
                    cnt_nxt   = TAIL_LOAD;
                end
            end
            TAIL: begin
                if (cnt == '0) begin
                    state_nxt = WAIT_LINK;
                    cnt_nxt   = LINK_LOAD;
                end
            end
            WAIT_LINK: begin
                // A link that comes up on the timeout cycle still wins.
                if (cu_s) begin
                    state_nxt = UP;
                    cnt_nxt   = '0;
                    loss_nxt  = '0;
                end else if (cnt == '0) begin
                    state_nxt = LEAD;
                    cnt_nxt   = LEAD_LOAD;
                    retry_inc = 1'b1;
                end
            end
            UP: begin
                cnt_nxt = cnt;
                if (cu_s) begin
                    loss_nxt = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_nxt = LEAD;
                    cnt_nxt   = LEAD_LOAD;
                    loss_nxt  = '0;
                    retry_inc = 1'b1;
                end else begin
                    loss_nxt = loss_cnt + LOSS_W'(1);
                end
            end
            default: begin
                state_nxt = LEAD;
                cnt_nxt   = LEAD_LOAD;
                loss_nxt  = '0;
            end
        endcase
        if (restart) begin
            state_nxt = LEAD;
            cnt_nxt   = LEAD_LOAD;
            loss_nxt  = '0;
            retry_inc = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            state       <= LEAD;
            cnt         <= LEAD_LOAD;
            loss_cnt    <= '0;
            retry_count <= '0;
            reset_pb    <= 1'b1;
            pma_init    <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            loss_cnt <= loss_nxt;
            if (retry_inc && (retry_count != '1)) begin
                retry_count <= retry_count + RETRY_W'(1);
            end
            reset_pb <= (state_nxt != WAIT_LINK) && (state_nxt != UP);
            pma_init <= (state_nxt == PMA);
            link_up  <= (state_nxt == UP);
        end
    end

endmodule

// File: tb/tb_qsfp_reset_sequencer.sv
// Directed bench for qsfp_reset_sequencer with shortened sequence parameters.
module tb_qsfp_reset_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int   SEQ_LEN = 42;  // 5 lead + 11 pma + 5 tail + 21 wait

    logic       clock;
    logic       reset_in;
    logic       restart;
    logic       channel_up;
    logic       reset_pb;
    logic       pma_init;
    logic       link_up;
    logic [7:0] retry_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int bad_order = 0;
    logic prev_pma = 1'b0;

    typedef struct {
        logic       rst;
        logic       rs;
        logic       cu;
        int         n;
        logic       e_rpb;
        logic       e_pma;
        logic       e_lu;
        logic [7:0] e_retry;
    } vec_t;

    vec_t vecs[$];

    qsfp_reset_sequencer #(
        .LEAD_CYCLES     (4),
        .PMA_HOLD_CYCLES (10),
        .TAIL_CYCLES     (4),
        .LINK_TIMEOUT    (20),
        .LOSS_FILTER     (3)
    ) dut (
        .clock       (clock),
        .reset_in    (reset_in),
        .restart     (restart),
        .channel_up  (channel_up),
        .reset_pb    (reset_pb),
        .pma_init    (pma_init),
        .link_up     (link_up),
        .retry_count (retry_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Ordering watchdog: pma_init only under reset_pb, and reset_pb never drops with pma_init.
    always @(negedge clock) begin
        if (!reset_in) begin
            if (pma_init === 1'b1 && reset_pb !== 1'b1) bad_order++;
            if (prev_pma === 1'b1 && pma_init === 1'b0 && reset_pb !== 1'b1) bad_order++;
        end
        prev_pma <= pma_init;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_in   = 1'b1;
        restart    = 1'b0;
        channel_up = 1'b0;
        tick(2);
        reset_in = 1'b0;
    endtask

    initial begin
        int   run;
        int   runs_seen;
        logic lu_seen;

        reset_in   = 1'b1;
        restart    = 1'b0;
        channel_up = 1'b0;

        //                rst rs cu  n  rpb pma lu retry
        vecs.push_back('{H, L, L,  3, H, L, L, 8'd0});  // 0 reset values
        vecs.push_back('{H, H, L,  1, H, L, L, 8'd0});  // 1 restart ignored in reset
        vecs.push_back('{L, L, L,  4, H, L, L, 8'd0});  // 2 lead
        vecs.push_back('{L, L, L,  1, H, H, L, 8'd0});  // 3 pma rises
        vecs.push_back('{L, L, L, 10, H, H, L, 8'd0});  // 4 pma held
        vecs.push_back('{L, L, L,  1, H, L, L, 8'd0});  // 5 tail
        vecs.push_back('{L, L, L,  4, H, L, L, 8'd0});  // 6 tail held
        vecs.push_back('{L, L, L,  1, L, L, L, 8'd0});  // 7 wait_link entry
        vecs.push_back('{L, L, H,  2, L, L, L, 8'd0});  // 8 channel_up rises
        vecs.push_back('{L, L, H,  1, L, L, H, 8'd0});  // 9 link_up 3 cycles later
        vecs.push_back('{L, L, L,  2, L, L, H, 8'd0});  // 10 two-cycle glitch
        vecs.push_back('{L, L, H,  4, L, L, H, 8'd0});  // 11 still up
        vecs.push_back('{L, L, L,  4, L, L, H, 8'd0});  // 12 real loss begins
        vecs.push_back('{L, L, L,  1, H, L, L, 8'd1});  // 13 loss -> lead
        vecs.push_back('{L, L, L,  4, H, L, L, 8'd1});  // 14 lead
        vecs.push_back('{L, L, L,  1, H, H, L, 8'd1});  // 15 pma
        vecs.push_back('{L, L, L,  3, H, H, L, 8'd1});  // 16 mid pma
        vecs.push_back('{H, L, L,  1, H, L, L, 8'd0});  // 17 reset mid pma
        vecs.push_back('{L, L, L,  4, H, L, L, 8'd0});  // 18 replay lead
        vecs.push_back('{L, L, L,  1, H, H, L, 8'd0});  // 19 pma
        vecs.push_back('{L, L, L, 10, H, H, L, 8'd0});  // 20 full pma hold
        vecs.push_back('{L, L, L,  1, H, L, L, 8'd0});  // 21 tail
        vecs.push_back('{L, L, L,  4, H, L, L, 8'd0});  // 22
        vecs.push_back('{L, L, L,  1, L, L, L, 8'd0});  // 23 wait_link
        vecs.push_back('{L, L, L, 20, L, L, L, 8'd0});  // 24 waiting
        vecs.push_back('{L, L, L,  1, H, L, L, 8'd1});  // 25 timeout

        for (int i = 0; i < vecs.size(); i++) begin
            reset_in   = vecs[i].rst;
            restart    = vecs[i].rs;
            channel_up = vecs[i].cu;
            tick(vecs[i].n);
            check1($sformatf("v%0d.reset_pb", i), reset_pb, vecs[i].e_rpb);
            check1($sformatf("v%0d.pma_init", i), pma_init, vecs[i].e_pma);
            check1($sformatf("v%0d.link_up", i), link_up, vecs[i].e_lu);
            check8($sformatf("v%0d.retry_count", i), retry_count, vecs[i].e_retry);
        end
        restart = 1'b0;

        // channel_up stuck low: three full sequences
        do_reset();
        run = 0;
        runs_seen = 0;
        lu_seen = 1'b0;
        for (int c = 0; c < 3 * SEQ_LEN; c++) begin
            tick(1);
            if (link_up !== 1'b0) lu_seen = 1'b1;
            if (reset_pb === 1'b0) begin
                run++;
            end else if (run > 0) begin
                check8($sformatf("stuck.wait_len%0d", runs_seen), 8'(run), 8'd21);
                runs_seen++;
                run = 0;
            end
        end
        check8("stuck.runs", 8'(runs_seen), 8'd3);
        check1("stuck.link_up_never", lu_seen, 1'b0);
        check8("stuck.retry", retry_count, 8'd3);

        // channel_up synchronized high exactly on the timeout cycle
        do_reset();
        tick(39);
        channel_up = 1'b1;
        tick(2);
        check1("late_cu.still_waiting", reset_pb, 1'b0);
        check1("late_cu.not_up_yet", link_up, 1'b0);
        tick(1);
        check1("late_cu.link_up", link_up, 1'b1);
        check8("late_cu.retry", retry_count, 8'd0);

        // restart coincident with the timeout cycle
        do_reset();
        tick(SEQ_LEN - 1);
        check1("rs_to.in_wait", reset_pb, 1'b0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check8("rs_to.retry_single", retry_count, 8'd1);
        check1("rs_to.reset_pb", reset_pb, 1'b1);
        tick(4);
        check1("rs_to.lead_len", pma_init, 1'b0);
        tick(1);
        check1("rs_to.pma_after_lead", pma_init, 1'b1);

        // saturation after many timeouts
        do_reset();
        tick(254 * SEQ_LEN);
        check8("sat.retry_254", retry_count, 8'd254);
        tick(6 * SEQ_LEN);
        check8("sat.retry_260", retry_count, 8'd255);
        tick(21);
        check1("sat.still_sequencing", reset_pb, 1'b0);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check8("sat.restart_holds", retry_count, 8'd255);

        n_cmp++;
        if (bad_order != 0) begin
            n_fail++;
            $display("FAIL ordering: got %0d violations expected 0", bad_order);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
